// File: rtl/oam_dma.sv
// OAM DMA engine: owns FF46 and, once written, masters the bus to copy
// LENGTH bytes from a source page into OAM at FE00.
module oam_dma #(
    parameter int SETUP_CYCLES = 4,
    parameter int READ_CYCLES  = 2,
    parameter int WRITE_CYCLES = 2,
    parameter int LENGTH       = 160
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] A_cpu,
    input  logic [7:0]  Di_cpu,
    input  logic        wr_cpu_n,
    output logic        cs_dma,
    output logic [7:0]  Do_reg,
    output logic [15:0] A_dma,
    input  logic [7:0]  Di_dma,
    output logic [7:0]  Do_dma,
    output logic        rd_dma_n,
    output logic        wr_dma_n,
    output logic        dma_active
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYCLES - 1);
    localparam logic [15:0] READ_LAST  = 16'(READ_CYCLES - 1);
    localparam logic [15:0] WRITE_LAST = 16'(WRITE_CYCLES - 1);
    localparam logic [7:0]  IDX_LAST   = 8'(LENGTH - 1);

    logic [1:0]  state;
    logic [15:0] cnt;
    logic [7:0]  idx;
    logic [7:0]  idx_next;
    logic [7:0]  src_page;
    logic [7:0]  eff_page;
    logic        hit;
    logic        hit_q;
    logic        trigger;

    assign cs_dma   = (A_cpu == 16'hFF46);
    assign hit      = cs_dma && !wr_cpu_n;
    // Edge-detect the write so a strobe held across several clocks fires once.
    assign trigger  = hit && !hit_q;
    // Pages E0-FF fold onto the C0-DF echo region.
    assign eff_page = (src_page >= 8'hE0) ? (src_page - 8'h20) : src_page;
    assign idx_next = idx + 8'd1;

    // NOTE: every register here updates with <=; the trigger branch sits ahead of
    // the state case so a retrigger aborts any byte in flight on the same edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx        <= '0;
            src_page   <= '0;
            hit_q      <= 1'b0;
            Do_reg     <= 8'hFF;
            A_dma      <= 16'h0000;
            Do_dma     <= 8'h00;
            rd_dma_n   <= 1'b1;
            wr_dma_n   <= 1'b1;
            dma_active <= 1'b0;
        end else begin
            hit_q <= hit;
            if (trigger) begin
                Do_reg     <= Di_cpu;
                src_page   <= Di_cpu;
                idx        <= '0;
                cnt        <= '0;
                state      <= S_SETUP;
                A_dma      <= 16'h0000;
                rd_dma_n   <= 1'b1;
                wr_dma_n   <= 1'b1;
                dma_active <= 1'b0;
            end else begin
                case (state)
                    S_SETUP: begin
                        if (cnt == SETUP_LAST) begin
                            cnt        <= '0;
                            state      <= S_READ;
                            A_dma      <= {eff_page, idx};
                            rd_dma_n   <= 1'b0;
                            dma_active <= 1'b1;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    S_READ: begin
                        if (cnt == READ_LAST) begin
                            cnt      <= '0;
                            state    <= S_WRITE;
                            Do_dma   <= Di_dma;
                            A_dma    <= 16'hFE00 + {8'h00, idx};
                            rd_dma_n <= 1'b1;
                            wr_dma_n <= 1'b0;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    S_WRITE: begin
                        if (cnt == WRITE_LAST) begin
                            cnt      <= '0;
                            wr_dma_n <= 1'b1;
                            if (idx == IDX_LAST) begin
                                state      <= S_IDLE;
                                A_dma      <= 16'h0000;
                                Do_dma     <= 8'h00;
                                dma_active <= 1'b0;
                            end else begin
                                idx      <= idx_next;
                                state    <= S_READ;
                                A_dma    <= {eff_page, idx_next};
                                rd_dma_n <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
